// File: rtl/ecc_pkg.sv
// ecc_pkg: shared defaults, nibble count and FSM state type for the ECC nibble transmitter.
package ecc_pkg;
  localparam int SIZE_DEF = 32;
  localparam int NIB_DEF = 4;
  localparam int NNIB_DEF = SIZE_DEF / NIB_DEF;
  localparam int TIMEOUT_DEF = 15000;
  typedef enum logic [1:0] {IDLE, HDR, SEND, WAIT} state_t;
endpackage

// File: rtl/ecc_nib_shift.sv
// ecc_nib_shift: one operand lane; parallel load, shift left by NIB, MSB nibble out.
module ecc_nib_shift
  import ecc_pkg::*;
#(
  parameter int SIZE = SIZE_DEF,
  parameter int NIB = NIB_DEF
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_load,
  input  logic            i_shift,
  input  logic [SIZE-1:0] i_d,
  output logic [NIB-1:0]  o_nib
);
  logic [SIZE-1:0] r_sr;
  always_ff @(posedge i_clk)
    if (i_rst) r_sr <= '0;
    else if (i_load) r_sr <= i_d;
    else if (i_shift) r_sr <= r_sr << NIB;
  assign o_nib = r_sr[SIZE-1 -: NIB];
endmodule

// File: rtl/ecc_nibble_tx.sv
// ecc_nibble_tx: serialises five SIZE-bit operands as a header strobe plus SIZE/NIB nibble beats.
// Optional WAIT watchdog enabled by defining ECC_TX_WATCHDOG_EN.
module ecc_nibble_tx
  import ecc_pkg::*;
#(
  parameter int SIZE = SIZE_DEF,
  parameter int NIB = NIB_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [SIZE-1:0] i_a,
  input  logic [SIZE-1:0] i_prime,
  input  logic [SIZE-1:0] i_px,
  input  logic [SIZE-1:0] i_py,
  input  logic [SIZE-1:0] i_k,
  output logic            o_start,
  output logic [NIB-1:0]  o_a,
  output logic [NIB-1:0]  o_prime,
  output logic [NIB-1:0]  o_px,
  output logic [NIB-1:0]  o_py,
  output logic [NIB-1:0]  o_k,
  input  logic            i_done,
  output logic            o_busy,
  output logic            o_timeout
);
  localparam int NN = SIZE / NIB;
  localparam int CW = $clog2(NN + 1);
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt, w_cnt;
  logic w_load, w_shift, w_expire, w_last;
  logic r_ready, r_start, r_busy, r_to;
  logic [SIZE-1:0] w_din [5];
  logic [NIB-1:0] w_nib [5];
  logic [NIB-1:0] r_lane [5];
  assign w_din = '{i_a, i_prime, i_px, i_py, i_k};
  assign w_load = r_state == IDLE && i_valid;
  assign w_last = r_cnt == CW'(NN - 1);
  // Lanes consume a nibble on every edge that lands in SEND, so the shifter advances in step.
  assign w_shift = w_next == SEND;
  for (genvar g = 0; g < 5; g++) begin : g_lane
    ecc_nib_shift #(.SIZE(SIZE), .NIB(NIB)) u_sh (
      .i_clk(i_clk), .i_rst(i_rst), .i_load(w_load), .i_shift(w_shift),
      .i_d(w_din[g]), .o_nib(w_nib[g])
    );
  end
`ifdef ECC_TX_WATCHDOG_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] r_wd;
  assign w_expire = r_state == WAIT && !i_done && r_wd == WW'(TIMEOUT - 1);
  always_ff @(posedge i_clk)
    r_wd <= (i_rst || r_state != WAIT) ? '0 : r_wd + 1'b1;
`else
  assign w_expire = 1'b0;
`endif
  always_comb begin
    w_next = r_state;
    w_cnt = r_cnt;
    case (r_state)
      IDLE: w_next = i_valid ? HDR : IDLE;
      HDR:  w_next = SEND;
      SEND: begin
        w_next = w_last ? WAIT : SEND;
        w_cnt = w_last ? '0 : r_cnt + 1'b1;
      end
      WAIT: w_next = (i_done || w_expire) ? IDLE : WAIT;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge i_clk)
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_ready <= 1'b1;
      r_start <= 1'b0;
      r_busy <= 1'b0;
      r_to <= 1'b0;
      for (int i = 0; i < 5; i++) r_lane[i] <= '0;
    end else begin
      r_state <= w_next;
      r_cnt <= w_cnt;
      r_ready <= w_next == IDLE;
      r_start <= w_next == HDR;
      r_busy <= w_next != IDLE;
      r_to <= w_expire;
      for (int i = 0; i < 5; i++) r_lane[i] <= w_shift ? w_nib[i] : '0;
    end
  assign o_ready = r_ready;
  assign o_start = r_start;
  assign o_busy = r_busy;
  assign o_timeout = r_to;
  assign o_a = r_lane[0];
  assign o_prime = r_lane[1];
  assign o_px = r_lane[2];
  assign o_py = r_lane[3];
  assign o_k = r_lane[4];
endmodule
